// File: rtl/audio_sample_buffer_if.sv
// audio_sample_buffer_if
// Groups the producer handshake and the serialiser-facing outputs of the
// audio sample buffer into one bundle.
//   in_data      : stereo sample {left[31:16], right[15:0]} from the producer
//   in_valid     : producer has a sample on in_data
//   in_ready     : buffer can accept a sample this cycle
//   mute         : force silence on aud_data without stalling the FIFO
//   underrun_clr : clears the sticky underrun flag
//   aud_data     : sample presented to the serialiser, held for a whole frame
//   sample_tick  : one-cycle pulse in the cycle aud_data takes a new value
//   fill         : FIFO occupancy, 0..DEPTH
//   underrun     : sticky flag, a frame found the FIFO empty
// master = producer/consumer side, slave = the buffer itself.
`timescale 1ns/1ps
interface audio_sample_buffer_if #(
    parameter int AW = 4
);
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mute;
    logic        underrun_clr;
    logic [31:0] aud_data;
    logic        sample_tick;
    logic [AW:0] fill;
    logic        underrun;

    modport master (
        output in_data, in_valid, mute, underrun_clr,
        input  in_ready, aud_data, sample_tick, fill, underrun
    );

    modport slave (
        input  in_data, in_valid, mute, underrun_clr,
        output in_ready, aud_data, sample_tick, fill, underrun
    );
endinterface

// File: rtl/audio_sample_buffer.sv
// audio_sample_buffer
// Stereo sample FIFO plus frame-rate pacer feeding the WM8731 PCM serialiser.
// A producer pushes samples over a valid/ready handshake; one sample is
// released per FRAME_LEN-cycle frame, at frame count UPDATE_PHASE, and held
// on aud_data for the whole frame so the serialiser may latch it anywhere.
// Ports:
//   clk_12 : 12 MHz codec clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : audio_sample_buffer_if.slave (handshake, mute, status, output)
`timescale 1ns/1ps
module audio_sample_buffer #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int FRAME_LEN    = 251,
    parameter int UPDATE_PHASE = 125
) (
    input  logic                   clk_12,
    input  logic                   rst_n,
    audio_sample_buffer_if.slave   bus
);

    localparam int             FCW     = $clog2(FRAME_LEN);
    localparam logic [AW:0]    FULL    = (AW+1)'(DEPTH);
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAME_LEN - 1);
    localparam logic [FCW-1:0] FC_UPD  = FCW'(UPDATE_PHASE);

    logic [FCW-1:0] fc_q, fc_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    fill_q, fill_d;
    logic [31:0]    aud_data_q, aud_data_d;
    logic           sample_tick_q, sample_tick_d;
    logic           underrun_q, underrun_d;
    logic [31:0]    mem_q [DEPTH];

    logic           update;
    logic           fifo_empty;
    logic           push;
    logic           pop;

    // Ready ignores a same-cycle pop on purpose: a full FIFO never accepts,
    // which keeps in_ready a simple function of registered state.
    assign bus.in_ready = rst_n && (fill_q != FULL);

    always_comb begin
        update     = (fc_q == FC_UPD);
        fifo_empty = (fill_q == '0);
        push       = bus.in_valid && bus.in_ready;
        // Emptiness is judged on the registered fill, so a write landing on
        // the update edge is not bypassed to the output.
        pop        = update && !fifo_empty;
    end

    always_comb begin
        fc_d     = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase

        // Muting still pops, so the drain rate is the same either way.
        aud_data_d = aud_data_q;
        if (update) begin
            aud_data_d = (pop && !bus.mute) ? mem_q[rd_ptr_q] : '0;
        end
        sample_tick_d = update;

        // A new underrun outranks a clear on the same edge.
        underrun_d = underrun_q;
        if (update && fifo_empty) begin
            underrun_d = 1'b1;
        end else if (bus.underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n) begin
            fc_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
            aud_data_q    <= '0;
            sample_tick_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            fc_q          <= fc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_q        <= fill_d;
            aud_data_q    <= aud_data_d;
            sample_tick_q <= sample_tick_d;
            underrun_q    <= underrun_d;
        end
    end

    // Sample storage needs no reset: contents are only read behind fill.
    always_ff @(posedge clk_12) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.aud_data    = aud_data_q;
    assign bus.sample_tick = sample_tick_q;
    assign bus.fill        = fill_q;
    assign bus.underrun    = underrun_q;

endmodule

// File: tb/tb_audio_sample_buffer.sv
// tb_audio_sample_buffer
// Self-checking bench for audio_sample_buffer: a queue-based reference model
// of the frame pacer is compared with the DUT after every clock edge, and the
// directed scenarios additionally pin literal values at known edge numbers.
`timescale 1ns/1ps
module tb_audio_sample_buffer;

    localparam int DEPTH        = 16;
    localparam int AW           = 4;
    localparam int FRAME_LEN    = 251;
    localparam int UPDATE_PHASE = 125;

    logic clk_12 = 1'b0;
    logic rst_n  = 1'b1;

    audio_sample_buffer_if #(.AW(AW)) bus ();

    audio_sample_buffer #(
        .DEPTH(DEPTH), .AW(AW), .FRAME_LEN(FRAME_LEN), .UPDATE_PHASE(UPDATE_PHASE)
    ) dut (
        .clk_12 (clk_12),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // Clock: 10 ns period
    always #5 clk_12 = ~clk_12;

    int n_cmp    = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    bit check_en = 1'b0;

    // Reference model state: the FIFO is just an ordered queue of samples
    logic [31:0] mq[$];
    int          m_fc    = 0;
    logic [31:0] m_aud   = '0;
    logic        m_tick  = 1'b0;
    logic        m_under = 1'b0;
    logic [31:0] m_pop;
    bit          m_upd;
    bit          m_was_empty;
    bit          m_acc;

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Model: one sample per frame leaves the queue at frame count UPDATE_PHASE;
    // a sample joins the queue whenever valid is high and the queue is not full.
    initial begin
        forever begin
            @(posedge clk_12 or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_fc    = 0;
                m_aud   = '0;
                m_tick  = 1'b0;
                m_under = 1'b0;
            end else begin
                m_upd       = (m_fc == UPDATE_PHASE);
                m_was_empty = (mq.size() == 0);
                m_acc       = bus.in_valid && (mq.size() < DEPTH);
                m_tick      = m_upd;
                if (m_upd) begin
                    if (!m_was_empty) begin
                        m_pop = mq.pop_front();
                        m_aud = bus.mute ? 32'h0 : m_pop;
                    end else begin
                        m_aud = 32'h0;
                    end
                end
                if (m_upd && m_was_empty) m_under = 1'b1;
                else if (bus.underrun_clr) m_under = 1'b0;
                if (m_acc) mq.push_back(bus.in_data);
                m_fc = (m_fc + 1) % FRAME_LEN;
            end
        end
    end

    // Compare process: DUT against model 3 ns after each rising edge
    initial begin
        forever begin
            @(posedge clk_12);
            #3;
            if (check_en) begin
                check_output("aud_data",    bus.aud_data, m_aud);
                check_output("sample_tick", {31'b0, bus.sample_tick}, {31'b0, m_tick});
                check_output("fill",        {27'b0, bus.fill}, 32'(mq.size()));
                check_output("underrun",    {31'b0, bus.underrun}, {31'b0, m_under});
                check_output("in_ready",    {31'b0, bus.in_ready},
                             {31'b0, rst_n && (mq.size() != DEPTH)});
            end
        end
    end

    // One rising edge passes; returns at the following falling edge
    task automatic step();
        @(negedge clk_12);
        edge_cnt++;
    endtask

    task automatic run_to(input int k);
        while (edge_cnt < k) step();
    endtask

    task automatic idle_inputs();
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.mute         = 1'b0;
        bus.underrun_clr = 1'b0;
    endtask

    // Hold reset for 3 cycles; release on a falling edge so edge 1 follows
    task automatic apply_reset();
        @(negedge clk_12);
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk_12);
        rst_n    = 1'b1;
        edge_cnt = 0;
    endtask

    task automatic apply_stimulus_random(input int n_edges);
        for (int i = 0; i < n_edges; i++) begin
            bus.in_valid     = ($urandom_range(0, 99) < ((i < n_edges / 2) ? 2 : 9));
            bus.in_data      = $urandom;
            bus.mute         = ($urandom_range(0, 4) == 0);
            bus.underrun_clr = ($urandom_range(0, 39) == 0);
            step();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #1;
        check_en = 1'b1;

        // Basic flow
        apply_reset();
        check_output("rst_aud_data", bus.aud_data, 32'h0);
        check_output("rst_fill", {27'b0, bus.fill}, 32'd0);
        bus.in_valid = 1'b1; bus.in_data = 32'h1111_2222; step();
        bus.in_data = 32'h3333_4444; step();
        bus.in_data = 32'h5555_6666; step();
        idle_inputs();
        check_output("basic_fill3", {27'b0, bus.fill}, 32'd3);
        run_to(125);
        check_output("basic_pre_tick", {31'b0, bus.sample_tick}, 32'd0);
        run_to(126);
        check_output("basic_aud126", bus.aud_data, 32'h1111_2222);
        check_output("basic_tick126", {31'b0, bus.sample_tick}, 32'd1);
        check_output("basic_fill2", {27'b0, bus.fill}, 32'd2);
        step();
        check_output("basic_tick127", {31'b0, bus.sample_tick}, 32'd0);
        run_to(377);
        check_output("basic_aud377", bus.aud_data, 32'h3333_4444);
        run_to(628);
        check_output("basic_aud628", bus.aud_data, 32'h5555_6666);
        check_output("basic_fill0", {27'b0, bus.fill}, 32'd0);
        check_output("basic_no_underrun", {31'b0, bus.underrun}, 32'd0);

        // Full FIFO
        apply_reset();
        bus.in_valid = 1'b1;
        for (int k = 1; k <= 127; k++) begin
            bus.in_data = 32'hF000_0000 + 32'(k);
            step();
            if (k == 16) begin
                check_output("full_fill16", {27'b0, bus.fill}, 32'd16);
                check_output("full_not_ready", {31'b0, bus.in_ready}, 32'd0);
            end
            if (k == 126) begin
                check_output("full_aud126", bus.aud_data, 32'hF000_0001);
                check_output("full_ready_again", {31'b0, bus.in_ready}, 32'd1);
            end
        end
        check_output("full_refill16", {27'b0, bus.fill}, 32'd16);
        idle_inputs();

        // Underrun set, clear, and set-wins-over-clear
        apply_reset();
        run_to(126);
        check_output("ur_aud126", bus.aud_data, 32'h0);
        check_output("ur_flag126", {31'b0, bus.underrun}, 32'd1);
        bus.underrun_clr = 1'b1; step(); bus.underrun_clr = 1'b0;
        check_output("ur_cleared", {31'b0, bus.underrun}, 32'd0);
        run_to(376);
        bus.underrun_clr = 1'b1; step(); bus.underrun_clr = 1'b0;
        check_output("ur_set_wins", {31'b0, bus.underrun}, 32'd1);

        // Write into empty FIFO on the update edge itself
        apply_reset();
        run_to(125);
        bus.in_valid = 1'b1; bus.in_data = 32'hAAAA_5555; step();
        idle_inputs();
        check_output("same_edge_aud", bus.aud_data, 32'h0);
        check_output("same_edge_underrun", {31'b0, bus.underrun}, 32'd1);
        check_output("same_edge_fill", {27'b0, bus.fill}, 32'd1);
        run_to(377);
        check_output("same_edge_aud377", bus.aud_data, 32'hAAAA_5555);

        // Mute
        apply_reset();
        bus.in_valid = 1'b1; bus.in_data = 32'h7FFF_8000; step();
        bus.in_data = 32'h0102_0304; step();
        idle_inputs();
        bus.mute = 1'b1;
        run_to(126);
        check_output("mute_aud126", bus.aud_data, 32'h0);
        check_output("mute_fill1", {27'b0, bus.fill}, 32'd1);
        bus.mute = 1'b0;
        run_to(377);
        check_output("mute_aud377", bus.aud_data, 32'h0102_0304);

        // Reset mid-stream
        apply_reset();
        bus.in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            bus.in_data = 32'h1234_0000 + 32'(k);
            step();
        end
        idle_inputs();
        run_to(60);
        check_output("mid_fill5", {27'b0, bus.fill}, 32'd5);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_aud", bus.aud_data, 32'h0);
        check_output("mid_rst_fill", {27'b0, bus.fill}, 32'd0);
        check_output("mid_rst_ready", {31'b0, bus.in_ready}, 32'd0);
        repeat (3) @(negedge clk_12);
        rst_n    = 1'b1;
        edge_cnt = 0;
        run_to(125);
        check_output("mid_no_early_tick", {31'b0, bus.sample_tick}, 32'd0);
        run_to(126);
        check_output("mid_tick126", {31'b0, bus.sample_tick}, 32'd1);
        check_output("mid_underrun", {31'b0, bus.underrun}, 32'd1);

        // Randomized traffic against the model
        apply_reset();
        apply_stimulus_random(3000);
        run_to(3300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
